// File: rtl/instr_word_assembler_if.sv
// Byte-in / word-out bundle between uart_rx, the word assembler and instruction memory.
// Latency: n/a (wires only).
// Backpressure: none; the byte strobe cannot be stalled and memory always accepts the write.
interface instr_word_assembler_if #(
   parameter int NB_DATA  = 8,
   parameter int NB_INSTR = 32,
   parameter int NB_ADDR  = 10
);
   logic                i_enable;
   logic [NB_DATA-1:0]  i_rx_data;
   logic                i_rx_done_tick;
   logic                i_clear;
   logic                o_mem_wr;
   logic [NB_ADDR-1:0]  o_mem_addr;
   logic [NB_INSTR-1:0] o_mem_data;
   logic [NB_ADDR:0]    o_word_count;
   logic                o_load_done;
   logic                o_full;

   // Byte source / loader controller side
   modport master (
      output i_enable, i_rx_data, i_rx_done_tick, i_clear,
      input  o_mem_wr, o_mem_addr, o_mem_data, o_word_count, o_load_done, o_full
   );

   // Assembler side
   modport slave (
      input  i_enable, i_rx_data, i_rx_done_tick, i_clear,
      output o_mem_wr, o_mem_addr, o_mem_data, o_word_count, o_load_done, o_full
   );
endinterface

// File: rtl/instr_word_assembler.sv
// Packs received UART bytes (MSB first) into instructions and writes them to consecutive word addresses.
// Latency: 4th byte strobe at edge N -> o_mem_wr high during cycle N+1 (one-cycle WRITE state).
// Backpressure: none; a strobe during WRITE starts the next word, strobes in DONE/FULL are dropped.
module instr_word_assembler #(
   parameter int                   NB_DATA   = 8,
   parameter int                   NB_INSTR  = 32,
   parameter int                   NB_ADDR   = 10,
   parameter logic [NB_INSTR-1:0]  HALT_WORD = 32'hFFFFFFFF
) (
   input logic                    clk,
   input logic                    reset,
   instr_word_assembler_if.slave  bus
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_COLLECT = 3'd1;
   localparam logic [2:0] ST_WRITE   = 3'd2;
   localparam logic [2:0] ST_DONE    = 3'd3;
   localparam logic [2:0] ST_FULL    = 3'd4;

   localparam logic [NB_ADDR-1:0] ADDR_LAST = '1;
   localparam logic [NB_ADDR:0]   COUNT_MAX = {1'b1, {NB_ADDR{1'b0}}};

   logic [2:0]          state;
   logic [1:0]          byte_cnt;
   logic [NB_INSTR-1:0] word;
   logic [NB_ADDR-1:0]  addr;
   logic [NB_ADDR:0]    word_count;
   logic                load_done;
   logic                full;
   logic                tick;
   logic [NB_INSTR-1:0] word_shifted;

   assign tick         = bus.i_enable && bus.i_rx_done_tick;
   assign word_shifted = {word[NB_INSTR-NB_DATA-1:0], bus.i_rx_data};

   // Load FSM: byte collection, one-cycle write, terminal HALT/FULL states
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         byte_cnt   <= 2'd0;
         word       <= '0;
         addr       <= '0;
         word_count <= '0;
         load_done  <= 1'b0;
         full       <= 1'b0;
      end else if (bus.i_clear) begin
         state      <= ST_IDLE;
         byte_cnt   <= 2'd0;
         word       <= '0;
         addr       <= '0;
         word_count <= '0;
         load_done  <= 1'b0;
         full       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               byte_cnt <= 2'd0;
               if (bus.i_enable) state <= ST_COLLECT;
            end
            ST_COLLECT: begin
               if (!bus.i_enable) begin
                  // partial word is abandoned; address and count survive
                  state    <= ST_IDLE;
                  byte_cnt <= 2'd0;
               end else if (tick) begin
                  word <= word_shifted;
                  if (byte_cnt == 2'd3) begin
                     byte_cnt <= 2'd0;
                     state    <= ST_WRITE;
                  end else begin
                     byte_cnt <= byte_cnt + 2'd1;
                  end
               end
            end
            ST_WRITE: begin
               addr <= addr + NB_ADDR'(1);
               if (word_count != COUNT_MAX) word_count <= word_count + (NB_ADDR+1)'(1);
               if (word == HALT_WORD) begin
                  state     <= ST_DONE;
                  load_done <= 1'b1;
               end else if (addr == ADDR_LAST) begin
                  state <= ST_FULL;
                  full  <= 1'b1;
               end else if (!bus.i_enable) begin
                  state <= ST_IDLE;
               end else begin
                  state <= ST_COLLECT;
                  // a byte landing in the write cycle becomes byte 0 of the next word
                  if (tick) begin
                     word     <= word_shifted;
                     byte_cnt <= 2'd1;
                  end
               end
            end
            ST_DONE, ST_FULL: begin
               state <= state;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Strobe is combinational from state so an async reset removes it at once
   always_comb begin
      bus.o_mem_wr     = (state == ST_WRITE) && !bus.i_clear;
      bus.o_mem_addr   = addr;
      bus.o_mem_data   = word;
      bus.o_word_count = word_count;
      bus.o_load_done  = load_done;
      bus.o_full       = full;
   end

endmodule
